// File: rtl/perf_counter_bank_pkg.sv
// Shared definitions for the performance counter bank: sizes, index types and
// the event numbering used by the pipeline stages that feed perf_events.
package perf_counter_bank_pkg;

    localparam int NUM_PERF_EVENTS    = 8;
    localparam int NUM_PERF_COUNTERS  = 2;
    localparam int PERF_COUNTER_WIDTH = 64;

    // Index width that stays legal (>= 1 bit) for single-entry configurations.
    function automatic int perf_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [perf_idx_w(NUM_PERF_EVENTS)-1:0]   perf_event_idx_t;
    typedef logic [perf_idx_w(NUM_PERF_COUNTERS)-1:0] perf_counter_idx_t;

    typedef enum logic [2:0] {
        PERF_UNCOND_BRANCH         = 3'd0,
        PERF_COND_BRANCH_TAKEN     = 3'd1,
        PERF_COND_BRANCH_NOT_TAKEN = 3'd2,
        PERF_ICACHE_MISS           = 3'd3,
        PERF_DCACHE_MISS           = 3'd4,
        PERF_DCACHE_HIT            = 3'd5,
        PERF_WB_RETIRE             = 3'd6,
        PERF_WB_STALL              = 3'd7
    } perf_event_e;

endpackage

// File: rtl/perf_counter_bank_if.sv
// Event/control/count bundle between the pipeline + control_registers (master)
// and the perf_counter_bank (slave).
interface perf_counter_bank_if
    import perf_counter_bank_pkg::*;
#(
    parameter int NUM_EVENTS    = NUM_PERF_EVENTS,
    parameter int NUM_COUNTERS  = NUM_PERF_COUNTERS,
    parameter int COUNTER_WIDTH = PERF_COUNTER_WIDTH
);
    localparam int EW  = perf_idx_w(NUM_EVENTS);
    localparam int CIW = perf_idx_w(NUM_COUNTERS);

    logic [NUM_EVENTS-1:0]                       perf_events;
    logic                                        cr_sel_we;
    logic [CIW-1:0]                              cr_sel_idx;
    logic [EW-1:0]                               cr_sel_event;
    logic                                        cr_sel_enable;
    logic                                        cr_clear_we;
    logic [CIW-1:0]                              cr_clear_idx;
    logic [NUM_COUNTERS-1:0][COUNTER_WIDTH-1:0]  perf_count;
    logic                                        perf_overflow_int;

    modport master (
        output perf_events, cr_sel_we, cr_sel_idx, cr_sel_event, cr_sel_enable,
               cr_clear_we, cr_clear_idx,
        input  perf_count, perf_overflow_int
    );

    modport slave (
        input  perf_events, cr_sel_we, cr_sel_idx, cr_sel_event, cr_sel_enable,
               cr_clear_we, cr_clear_idx,
        output perf_count, perf_overflow_int
    );

endinterface

// File: rtl/perf_counter_bank_slice.sv
// One programmable counter: select/enable register, counter with clear-over-
// increment priority, and a sticky wrap flag when PERF_OVERFLOW_INT_EN is defined.
module perf_counter_slice #(
    parameter int EW     = 3,
    parameter int EV_PAD = 8,
    parameter int CW     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [EV_PAD-1:0] i_events,
    input  logic              i_sel_we,
    input  logic [EW-1:0]     i_sel_event,
    input  logic              i_sel_enable,
    input  logic              i_clear,
    output logic [CW-1:0]     o_count
`ifdef PERF_OVERFLOW_INT_EN
    ,
    output logic              o_ovf
`endif
);

    logic [EW-1:0] r_sel;
    logic          r_en;
    logic [CW-1:0] r_count;
    logic          w_hit;

    // Padded event vector: out-of-range selects land on constant-zero bits.
    assign w_hit = r_en && i_events[r_sel];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel <= '0;
            r_en  <= 1'b0;
        end else if (i_sel_we) begin
            r_sel <= i_sel_event;
            r_en  <= i_sel_enable;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_sel_we || i_clear) begin
            r_count <= '0;
        end else if (w_hit) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

`ifdef PERF_OVERFLOW_INT_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (reset || i_sel_we || i_clear) begin
            r_ovf <= 1'b0;
        end else if (w_hit && (&r_count)) begin
            r_ovf <= 1'b1;
        end
    end

    assign o_ovf = r_ovf;
`endif

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of programmable event counters fed by registered pipeline event pulses.
// Optional overflow interrupt: define PERF_OVERFLOW_INT_EN.
module perf_counter_bank
    import perf_counter_bank_pkg::*;
#(
    parameter int NUM_EVENTS    = NUM_PERF_EVENTS,
    parameter int NUM_COUNTERS  = NUM_PERF_COUNTERS,
    parameter int COUNTER_WIDTH = PERF_COUNTER_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    perf_counter_bank_if.slave  bus
);

    localparam int EW     = perf_idx_w(NUM_EVENTS);
    localparam int CIW    = perf_idx_w(NUM_COUNTERS);
    localparam int EV_PAD = 1 << EW;

    logic [NUM_EVENTS-1:0] r_event_q;
    logic [EV_PAD-1:0]     w_events_pad;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_event_q <= '0;
        end else begin
            r_event_q <= bus.perf_events;
        end
    end

    assign w_events_pad = EV_PAD'(r_event_q);

`ifdef PERF_OVERFLOW_INT_EN
    logic [NUM_COUNTERS-1:0] w_ovf;
    logic                    r_ovf_int;
`endif

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_slice
        logic w_sel_we;
        logic w_clear;

        assign w_sel_we = bus.cr_sel_we   && (bus.cr_sel_idx   == CIW'(i));
        assign w_clear  = bus.cr_clear_we && (bus.cr_clear_idx == CIW'(i));

        perf_counter_slice #(
            .EW     (EW),
            .EV_PAD (EV_PAD),
            .CW     (COUNTER_WIDTH)
        ) u_slice (
            .clk          (clk),
            .reset        (reset),
            .i_events     (w_events_pad),
            .i_sel_we     (w_sel_we),
            .i_sel_event  (bus.cr_sel_event),
            .i_sel_enable (bus.cr_sel_enable),
            .i_clear      (w_clear),
            .o_count      (bus.perf_count[i])
`ifdef PERF_OVERFLOW_INT_EN
            ,
            .o_ovf        (w_ovf[i])
`endif
        );
    end

`ifdef PERF_OVERFLOW_INT_EN
    // Registered OR of the sticky flags: rises one edge after the wrap edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_int <= 1'b0;
        end else begin
            r_ovf_int <= |w_ovf;
        end
    end

    assign bus.perf_overflow_int = r_ovf_int;
`else
    assign bus.perf_overflow_int = 1'b0;
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed vector bench for perf_counter_bank (table + hand-written wrap,
// saturating-traffic and reset sequences).
module tb_perf_counter_bank;
    import perf_counter_bank_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    perf_counter_bank_if #(
        .NUM_EVENTS    (8),
        .NUM_COUNTERS  (2),
        .COUNTER_WIDTH (64)
    ) bus ();

    perf_counter_bank #(
        .NUM_EVENTS    (8),
        .NUM_COUNTERS  (2),
        .COUNTER_WIDTH (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef PERF_OVERFLOW_INT_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  ev;
        logic        sel_we;
        logic        sel_idx;
        logic [2:0]  sel_ev;
        logic        sel_en;
        logic        clr_we;
        logic        clr_idx;
        logic [63:0] e0;
        logic [63:0] e1;
    } vec_t;

    vec_t vt [31];

    function automatic vec_t mk(input logic [7:0] ev, input logic sel_we,
                                input logic sel_idx, input logic [2:0] sel_ev,
                                input logic sel_en, input logic clr_we,
                                input logic clr_idx, input logic [63:0] e0,
                                input logic [63:0] e1);
        vec_t v;
        v.ev = ev; v.sel_we = sel_we; v.sel_idx = sel_idx; v.sel_ev = sel_ev;
        v.sel_en = sel_en; v.clr_we = clr_we; v.clr_idx = clr_idx;
        v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.perf_events   = '0;
        bus.cr_sel_we     = 1'b0;
        bus.cr_sel_idx    = '0;
        bus.cr_sel_event  = '0;
        bus.cr_sel_enable = 1'b0;
        bus.cr_clear_we   = 1'b0;
        bus.cr_clear_idx  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Row = inputs held for one edge, then counts expected after that edge.
        vt[0]  = mk(8'h00, 1, 0, PERF_COND_BRANCH_TAKEN, 1, 0, 0, 0, 0);
        vt[1]  = mk(8'h02, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[2]  = mk(8'h02, 0, 0, 0, 0, 0, 0, 1, 0);
        vt[3]  = mk(8'h02, 0, 0, 0, 0, 0, 0, 2, 0);
        vt[4]  = mk(8'h02, 0, 0, 0, 0, 0, 0, 3, 0);
        vt[5]  = mk(8'h02, 0, 0, 0, 0, 0, 0, 4, 0);
        vt[6]  = mk(8'h00, 0, 0, 0, 0, 0, 0, 5, 0);
        vt[7]  = mk(8'h00, 0, 0, 0, 0, 0, 0, 5, 0);
        vt[8]  = mk(8'h00, 1, 1, PERF_COND_BRANCH_NOT_TAKEN, 0, 0, 0, 5, 0);
        vt[9]  = mk(8'h04, 0, 0, 0, 0, 0, 0, 5, 0);
        vt[10] = mk(8'h04, 0, 0, 0, 0, 0, 0, 5, 0);
        vt[11] = mk(8'h04, 0, 0, 0, 0, 0, 0, 5, 0);
        vt[12] = mk(8'h00, 0, 0, 0, 0, 0, 0, 5, 0);
        vt[13] = mk(8'h00, 1, 1, PERF_COND_BRANCH_NOT_TAKEN, 1, 0, 0, 5, 0);
        vt[14] = mk(8'h04, 0, 0, 0, 0, 0, 0, 5, 0);
        vt[15] = mk(8'h04, 0, 0, 0, 0, 0, 0, 5, 1);
        vt[16] = mk(8'h04, 0, 0, 0, 0, 0, 0, 5, 2);
        vt[17] = mk(8'h00, 0, 0, 0, 0, 0, 0, 5, 3);
        vt[18] = mk(8'h02, 0, 0, 0, 0, 0, 0, 5, 3);
        vt[19] = mk(8'h02, 0, 0, 0, 0, 0, 0, 6, 3);
        vt[20] = mk(8'h02, 0, 0, 0, 0, 0, 0, 7, 3);
        vt[21] = mk(8'h02, 0, 0, 0, 0, 0, 0, 8, 3);
        vt[22] = mk(8'h02, 0, 0, 0, 0, 0, 0, 9, 3);
        vt[23] = mk(8'h00, 0, 0, 0, 0, 0, 0, 10, 3);
        vt[24] = mk(8'h02, 0, 0, 0, 0, 0, 0, 10, 3);
        vt[25] = mk(8'h00, 0, 0, 0, 0, 1, 0, 0, 3);
        vt[26] = mk(8'h02, 0, 0, 0, 0, 0, 0, 0, 3);
        vt[27] = mk(8'h00, 0, 0, 0, 0, 0, 0, 1, 3);
        vt[28] = mk(8'h00, 1, 1, PERF_ICACHE_MISS, 1, 1, 1, 1, 0);
        vt[29] = mk(8'h08, 0, 0, 0, 0, 0, 0, 1, 0);
        vt[30] = mk(8'h00, 0, 0, 0, 0, 0, 0, 1, 1);

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check("reset_count0", bus.perf_count[0], 64'd0);
        check("reset_count1", bus.perf_count[1], 64'd0);
        check("reset_ovf_int", {63'd0, bus.perf_overflow_int}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 31; i++) begin
            bus.perf_events   = vt[i].ev;
            bus.cr_sel_we     = vt[i].sel_we;
            bus.cr_sel_idx    = vt[i].sel_idx;
            bus.cr_sel_event  = vt[i].sel_ev;
            bus.cr_sel_enable = vt[i].sel_en;
            bus.cr_clear_we   = vt[i].clr_we;
            bus.cr_clear_idx  = vt[i].clr_idx;
            tick();
            check($sformatf("vec%0d_count0", i), bus.perf_count[0], vt[i].e0);
            check($sformatf("vec%0d_count1", i), bus.perf_count[1], vt[i].e1);
        end
        idle_inputs();

        // Wrap: counter 0 still counts event 1; event_q is idle here.
        dut.g_slice[0].u_slice.r_count = 64'hFFFF_FFFF_FFFF_FFFE;
        bus.perf_events = 8'h02;
        tick();
        check("wrap_fe", bus.perf_count[0], 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        check("wrap_ff", bus.perf_count[0], 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check("wrap_zero", bus.perf_count[0], 64'd0);
        check("wrap_int_at_edge", {63'd0, bus.perf_overflow_int}, 64'd0);
        bus.perf_events = 8'h00;
        tick();
        check("wrap_one", bus.perf_count[0], 64'd1);
        check("wrap_int_next", {63'd0, bus.perf_overflow_int}, {63'd0, OVF_EXP});
        tick();
        tick();
        check("wrap_int_held", {63'd0, bus.perf_overflow_int}, {63'd0, OVF_EXP});
        check("wrap_count1_untouched", bus.perf_count[1], 64'd1);
        bus.cr_clear_we  = 1'b1;
        bus.cr_clear_idx = 1'b0;
        tick();
        idle_inputs();
        check("clr_count0", bus.perf_count[0], 64'd0);
        check("clr_int_lag", {63'd0, bus.perf_overflow_int}, {63'd0, OVF_EXP});
        tick();
        check("clr_int_drop", {63'd0, bus.perf_overflow_int}, 64'd0);

        // Every event firing every cycle, counters on different events.
        bus.cr_sel_we     = 1'b1;
        bus.cr_sel_idx    = 1'b0;
        bus.cr_sel_event  = PERF_DCACHE_HIT;
        bus.cr_sel_enable = 1'b1;
        tick();
        bus.cr_sel_idx    = 1'b1;
        bus.cr_sel_event  = PERF_WB_RETIRE;
        bus.perf_events   = 8'hFF;
        tick();
        check("all_start0", bus.perf_count[0], 64'd0);
        check("all_start1", bus.perf_count[1], 64'd0);
        bus.cr_sel_we = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("all_c0_k%0d", k), bus.perf_count[0], 64'(k));
            check($sformatf("all_c1_k%0d", k), bus.perf_count[1], 64'(k));
        end

        // Wrap under traffic, then reset mid-count.
        dut.g_slice[0].u_slice.r_count = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        check("busy_wrap0", bus.perf_count[0], 64'd0);
        check("busy_count1", bus.perf_count[1], 64'd9);
        tick();
        check("busy_int", {63'd0, bus.perf_overflow_int}, {63'd0, OVF_EXP});
        reset = 1'b1;
        tick();
        check("midreset_count0", bus.perf_count[0], 64'd0);
        check("midreset_count1", bus.perf_count[1], 64'd0);
        check("midreset_int", {63'd0, bus.perf_overflow_int}, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("postreset_count0", bus.perf_count[0], 64'd0);
        check("postreset_count1", bus.perf_count[1], 64'd0);
        check("postreset_int", {63'd0, bus.perf_overflow_int}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
